cpu_io_ctrl: RTL and testbench

// - Parametrised I/O controller between top_CPU and external stimulus/peripherals; generalises the single 4-bit inr input / 16-bit outvalue output.
// - IN_CH buffered input channels (one FIFO each) read by the CPU on demand.
// - One output register drained by a valid/ready handshake.
// - Sits beside the CPU core; the CPU reads input channels and writes output through strobes.

---
 rtl/cpu_io_pkg.sv | 20 ++
 rtl/cpu_io_ctrl_fifo.sv | 46 ++++
 rtl/cpu_io_ctrl.sv | 112 +++++++++++
 tb/tb_cpu_io_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_io_pkg.sv
// Shared constants, pointer-width helper and read-response type for the CPU I/O controller.
package cpu_io_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_IN_W   = 4;
  localparam int MAX_IN_CH  = 8;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // The data field only has to carry a zero-extended IN_W sample, so the
  // package default width is enough; the top widens or narrows it to DATA_W.
  typedef struct packed {
    logic                  valid;
    logic                  err;
    logic [DEF_DATA_W-1:0] data;
  } rd_resp_t;

endpackage

// File: rtl/cpu_io_ctrl_fifo.sv
// io_fifo: single-clock FIFO with extra-MSB pointers; full/empty come from registered state only.
module io_fifo
  import cpu_io_pkg::*;
#(
  parameter int W     = 4,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic          do_push, do_pop;

  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rp[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + PW'(1);
      if (do_pop)  rp <= rp + PW'(1);
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/cpu_io_ctrl.sv
// CPU I/O controller: IN_CH buffered input channels popped on rd_en, one handshaked output register.
// Define IO_OVF_CNT_EN to build the per-channel saturating overflow counters.
module cpu_io_ctrl
  import cpu_io_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int IN_W       = DEF_IN_W,
  parameter int IN_CH      = 2,
  parameter int FIFO_DEPTH = 8,
  localparam int CH_W      = (IN_CH > 1) ? $clog2(IN_CH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [IN_CH-1:0]      in_valid,
  input  logic [IN_CH*IN_W-1:0] in_data,
  output logic [IN_CH-1:0]      in_ready,
  input  logic                  rd_en,
  input  logic [CH_W-1:0]       rd_ch,
  output logic                  rd_valid,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_err,
  input  logic                  wr_en,
  input  logic [DATA_W-1:0]     wr_data,
  output logic                  wr_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  input  logic                  out_ready,
  output logic [IN_CH*8-1:0]    ovf_cnt
);

  localparam int NSEL = 1 << CH_W;

  logic [IN_CH-1:0]            full, empty, pop;
  logic [IN_CH-1:0][IN_W-1:0]  dout;
  logic [NSEL-1:0]             sel_ok, empty_ext;
  logic [IN_W-1:0]             dout_ext [NSEL];
  logic                        hit;
  rd_resp_t                    resp_q;

  for (genvar c = 0; c < IN_CH; c++) begin : g_ch
    assign pop[c] = rd_en && (rd_ch == CH_W'(c));
    io_fifo #(.W(IN_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (in_valid[c]),
      .din   (in_data[c*IN_W +: IN_W]),
      .pop   (pop[c]),
      .dout  (dout[c]),
      .full  (full[c]),
      .empty (empty[c])
    );
  end

  assign in_ready = ~full;

  // Pad the select space to a power of two; unused codes read as an invalid, empty channel.
  for (genvar i = 0; i < NSEL; i++) begin : g_sel
    if (i < IN_CH) begin : g_real
      assign sel_ok[i]    = 1'b1;
      assign empty_ext[i] = empty[i];
      assign dout_ext[i]  = dout[i];
    end else begin : g_pad
      assign sel_ok[i]    = 1'b0;
      assign empty_ext[i] = 1'b1;
      assign dout_ext[i]  = '0;
    end
  end

  assign hit = rd_en && sel_ok[rd_ch] && !empty_ext[rd_ch];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_q <= '0;
    end else begin
      resp_q.valid <= hit;
      resp_q.err   <= rd_en && !hit;
      if (hit) resp_q.data <= DEF_DATA_W'(dout_ext[rd_ch]);
    end
  end

  assign rd_valid = resp_q.valid;
  assign rd_err   = resp_q.err;
  assign rd_data  = DATA_W'(resp_q.data);

  assign wr_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (wr_en && wr_ready) begin
      out_valid <= 1'b1;
      out_data  <= wr_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef IO_OVF_CNT_EN
  for (genvar c = 0; c < IN_CH; c++) begin : g_ovf
    logic [7:0] cnt;
    always_ff @(posedge clk or negedge reset) begin
      if (!reset)                                cnt <= '0;
      else if (in_valid[c] && full[c] && cnt != 8'hFF) cnt <= cnt + 8'd1;
    end
    assign ovf_cnt[c*8 +: 8] = cnt;
  end
`else
  assign ovf_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_io_ctrl.sv
// Directed bench for cpu_io_ctrl (IN_CH=2 main instance plus an IN_CH=1 instance for invalid-channel reads).
module tb_cpu_io_ctrl;

`ifdef IO_OVF_CNT_EN
  localparam logic [7:0] EXP_OVF = 8'd1;
`else
  localparam logic [7:0] EXP_OVF = 8'd0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  in_valid, in_ready;
  logic [7:0]  in_data;
  logic        rd_en, rd_ch, rd_valid, rd_err;
  logic [15:0] rd_data;
  logic        wr_en, wr_ready, out_valid, out_ready;
  logic [15:0] wr_data, out_data, ovf_cnt;

  logic        in_valid1, in_ready1, rd_en1, rd_ch1, rd_valid1, rd_err1;
  logic [3:0]  in_data1;
  logic [15:0] rd_data1, wr_data1, out_data1;
  logic        wr_en1, wr_ready1, out_valid1, out_ready1;
  logic [7:0]  ovf_cnt1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cpu_io_ctrl #(.DATA_W(16), .IN_W(4), .IN_CH(2), .FIFO_DEPTH(8)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .rd_en(rd_en), .rd_ch(rd_ch), .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err),
    .wr_en(wr_en), .wr_data(wr_data), .wr_ready(wr_ready), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .ovf_cnt(ovf_cnt)
  );

  cpu_io_ctrl #(.DATA_W(16), .IN_W(4), .IN_CH(1), .FIFO_DEPTH(8)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_data(in_data1), .in_ready(in_ready1),
    .rd_en(rd_en1), .rd_ch(rd_ch1), .rd_valid(rd_valid1), .rd_data(rd_data1), .rd_err(rd_err1),
    .wr_en(wr_en1), .wr_data(wr_data1), .wr_ready(wr_ready1), .out_valid(out_valid1),
    .out_data(out_data1), .out_ready(out_ready1), .ovf_cnt(ovf_cnt1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input int ch, input logic [3:0] v);
    in_valid = 2'b01 << ch;
    in_data  = '0;
    in_data[ch*4 +: 4] = v;
    step();
    in_valid = '0;
  endtask

  task automatic pop_chk(input int ch, input logic [15:0] exp, input string tag);
    rd_en = 1'b1;
    rd_ch = 1'(ch);
    step();
    rd_en = 1'b0;
    check({tag, "_valid"}, 32'(rd_valid), 32'd1);
    check({tag, "_data"},  32'(rd_data),  32'(exp));
  endtask

  logic [3:0] fill [8];

  initial begin
    reset = 1'b0; in_valid = 2'b11; in_data = 8'hFF; rd_en = 0; rd_ch = 0;
    wr_en = 0; wr_data = '0; out_ready = 0;
    in_valid1 = 0; in_data1 = '0; rd_en1 = 0; rd_ch1 = 0;
    wr_en1 = 0; wr_data1 = '0; out_ready1 = 0;

    // Reset held with pushes requested: nothing may be stored
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_ovf",       32'(ovf_cnt),   32'd0);
    check("rst_rd_valid",  32'(rd_valid),  32'd0);
    check("rst_rd_err",    32'(rd_err),    32'd0);
    check("rst_rd_data",   32'(rd_data),   32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_wr_ready",  32'(wr_ready),  32'd1);
    check("rst1_wr_ready", 32'(wr_ready1), 32'd1);
    reset = 1'b1; in_valid = '0;
    step();
    check("rel_in_ready",  32'(in_ready),  32'h3);
    check("rel_in_ready1", 32'(in_ready1), 32'h1);

    // FIFO order on channel 0
    push(0, 4'h5); push(0, 4'h6); push(0, 4'h1);
    pop_chk(0, 16'h0005, "ord0");
    pop_chk(0, 16'h0006, "ord1");
    pop_chk(0, 16'h0001, "ord2");
    step();
    check("ord_pulse", 32'(rd_valid), 32'd0);
    check("ord_hold",  32'(rd_data),  32'h0001);

    // Fill channel 1, overflow once, drain through the pointer wrap
    for (int i = 0; i < 8; i++) fill[i] = 4'(i * 3 + 2);
    for (int i = 0; i < 8; i++) push(1, fill[i]);
    check("full_in_ready", 32'(in_ready), 32'h1);
    push(1, 4'hD);
    check("ovf_in_ready", 32'(in_ready),     32'h1);
    check("ovf_cnt1",     32'(ovf_cnt[15:8]), 32'(EXP_OVF));
    check("ovf_cnt0",     32'(ovf_cnt[7:0]),  32'd0);
    for (int i = 0; i < 8; i++) pop_chk(1, 16'(fill[i]), $sformatf("wrap%0d", i));
    check("drain_in_ready", 32'(in_ready), 32'h3);

    // Empty read leaves rd_data alone
    rd_en = 1; rd_ch = 0;
    step();
    rd_en = 0;
    check("empty_err",   32'(rd_err),   32'd1);
    check("empty_valid", 32'(rd_valid), 32'd0);
    check("empty_hold",  32'(rd_data),  32'h0007);
    step();
    check("err_pulse", 32'(rd_err), 32'd0);

    // Pop of empty FIFO with same-cycle push: no bypass, push kept
    rd_en = 1; rd_ch = 0; in_valid = 2'b01; in_data = 8'h0C;
    step();
    rd_en = 0; in_valid = '0;
    check("nobyp_err",  32'(rd_err),  32'd1);
    check("nobyp_hold", 32'(rd_data), 32'h0007);
    pop_chk(0, 16'h000C, "nobyp_pop");

    // IN_CH=1: rd_ch=1 is invalid even with data on channel 0
    in_valid1 = 1; in_data1 = 4'h9;
    step();
    in_valid1 = 0; rd_en1 = 1; rd_ch1 = 1;
    step();
    rd_en1 = 0;
    check("inv_err",   32'(rd_err1),   32'd1);
    check("inv_valid", 32'(rd_valid1), 32'd0);
    check("inv_data",  32'(rd_data1),  32'd0);
    rd_en1 = 1; rd_ch1 = 0;
    step();
    rd_en1 = 0;
    check("ch1_valid", 32'(rd_valid1), 32'd1);
    check("ch1_data",  32'(rd_data1),  32'h0009);
    check("ch1_ovf",   32'(ovf_cnt1),  32'd0);
    check("ch1_out",   32'({out_valid1, out_data1}), 32'd0);

    // Output handshake
    wr_en = 1; wr_data = 16'h1234; out_ready = 0;
    step();
    check("wr1_valid", 32'(out_valid), 32'd1);
    check("wr1_data",  32'(out_data),  32'h1234);
    check("wr1_ready", 32'(wr_ready),  32'd0);
    wr_data = 16'hABCD;
    step();
    check("drop_data",  32'(out_data),  32'h1234);
    check("drop_valid", 32'(out_valid), 32'd1);
    out_ready = 1; wr_data = 16'h00FF;
    #1;
    check("b2b_ready", 32'(wr_ready), 32'd1);
    step();
    check("b2b_data",  32'(out_data),  32'h00FF);
    check("b2b_valid", 32'(out_valid), 32'd1);
    wr_en = 0;
    step();
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_hold",  32'(out_data),  32'h00FF);

    // Asynchronous reset mid-operation
    push(0, 4'hA); push(0, 4'hB); push(0, 4'hC);
    out_ready = 0; wr_en = 1; wr_data = 16'h5555;
    step();
    wr_en = 0;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_data",  32'(out_data),  32'd0);
    check("arst_rd_data",   32'(rd_data),   32'd0);
    check("arst_ovf",       32'(ovf_cnt),   32'd0);
    check("arst_in_ready",  32'(in_ready),  32'h3);
    step();
    reset = 1'b1;
    rd_en = 1; rd_ch = 0;
    step();
    rd_en = 0;
    check("post_rst_err",   32'(rd_err),   32'd1);
    check("post_rst_valid", 32'(rd_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
